ccr_unit: RTL and testbench

Condition-code register and flag consumer for the processor's execute stage. Latches the zero, carry, overflow and negative flags produced by the ALU under a per-instruction write mask, and applies SETC/CLRC. Resolves conditional jumps (JZ/JN/JC/JMP) against the registered flags and clears the tested flag once a jump is taken. Keeps a small LIFO of saved flag words so that interrupt entry and RTI preserve and restore the flags.

---
 rtl/ccr_unit.sv | 110 +++++++++++
 tb/tb_ccr_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ccr_unit.sv
// Condition-code register with branch resolution and a LIFO of saved flag words.
// Latency: ccr/stack status update one clock after inputs; br_taken is combinational.
// Backpressure: none; every input is sampled each cycle and never stalled.
module ccr_unit #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_zero,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   input  logic       alu_negative,
   input  logic [3:0] flag_we,
   input  logic       setc,
   input  logic       clrc,
   input  logic       br_valid,
   input  logic [1:0] br_cond,
   output logic       br_taken,
   input  logic       int_save,
   input  logic       int_restore,
   output logic [3:0] ccr,
   output logic       stack_full,
   output logic       stack_empty,
   output logic       stack_err
);

   // Count needs to hold 0..DEPTH; entry index needs 0..DEPTH-1.
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] COND_JZ  = 2'b00;
   localparam logic [1:0] COND_JN  = 2'b01;
   localparam logic [1:0] COND_JC  = 2'b10;

   logic [3:0]    stack_mem [DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] count_m1;
   logic [AW-1:0] top_idx;
   logic [AW-1:0] push_idx;
   logic [3:0]    alu_flags;
   logic [3:0]    ccr_nxt;
   logic          do_push;
   logic          do_pop;
   logic          err_set;

   assign alu_flags   = {alu_overflow, alu_negative, alu_carry, alu_zero};
   assign stack_full  = (count == CW'(DEPTH));
   assign stack_empty = (count == '0);
   assign count_m1    = count - CW'(1);
   assign top_idx     = count_m1[AW-1:0];
   assign push_idx    = count[AW-1:0];

   // A simultaneous save and restore cancels both and is flagged as misuse.
   assign do_push = int_save & ~int_restore & ~stack_full;
   assign do_pop  = int_restore & ~int_save & ~stack_empty;
   assign err_set = (int_save & int_restore)
                  | (int_save & ~int_restore & stack_full)
                  | (int_restore & ~int_save & stack_empty);

   // Branch resolution looks only at the registered flags, never the ALU outputs.
   always_comb begin
      br_taken = 1'b0;
      if (br_valid) begin
         case (br_cond)
            COND_JZ: br_taken = ccr[0];
            COND_JN: br_taken = ccr[2];
            COND_JC: br_taken = ccr[1];
            default: br_taken = 1'b1;
         endcase
      end
   end

   // Next flags: restore base, then ALU writes, then SETC/CLRC, then taken-branch clear.
   always_comb begin
      ccr_nxt = do_pop ? stack_mem[top_idx] : ccr;
      for (int i = 0; i < 4; i++) begin
         if (flag_we[i]) ccr_nxt[i] = alu_flags[i];
      end
      if (setc)      ccr_nxt[1] = 1'b1;
      else if (clrc) ccr_nxt[1] = 1'b0;
      if (br_taken) begin
         case (br_cond)
            COND_JZ: ccr_nxt[0] = 1'b0;
            COND_JN: ccr_nxt[2] = 1'b0;
            COND_JC: ccr_nxt[1] = 1'b0;
            default: ;
         endcase
      end
   end

   // Flag register, stack depth and sticky error; reset drops every saved entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ccr       <= 4'b0000;
         count     <= '0;
         stack_err <= 1'b0;
      end else begin
         ccr <= ccr_nxt;
         if (do_push)     count <= count + CW'(1);
         else if (do_pop) count <= count_m1;
         if (err_set) stack_err <= 1'b1;
      end
   end

   // Stack storage pushes the pre-update flags; entries above the count are don't-care.
   always_ff @(posedge clk) begin
      if (!rst && do_push) stack_mem[push_idx] <= ccr;
   end

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_zero, alu_carry, alu_overflow, alu_negative;
   logic [3:0] flag_we;
   logic       setc, clrc;
   logic       br_valid;
   logic [1:0] br_cond;
   logic       br_taken;
   logic       int_save, int_restore;
   logic [3:0] ccr;
   logic       stack_full, stack_empty, stack_err;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: flags, saved words as a queue, sticky error.
   logic [3:0] m_ccr = 4'b0000;
   logic [3:0] m_stack [$];
   logic       m_err = 1'b0;
   logic       br_seen;

   ccr_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_negative(alu_negative),
      .flag_we(flag_we), .setc(setc), .clrc(clrc),
      .br_valid(br_valid), .br_cond(br_cond), .br_taken(br_taken),
      .int_save(int_save), .int_restore(int_restore),
      .ccr(ccr), .stack_full(stack_full), .stack_empty(stack_empty),
      .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic exp_taken(logic v, logic [1:0] c, logic [3:0] f);
      if (!v) return 1'b0;
      case (c)
         2'd0:    return f[0];   // JZ
         2'd1:    return f[2];   // JN
         2'd2:    return f[1];   // JC
         default: return 1'b1;   // JMP
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: alu is {V,N,C,Z}. Checks br_taken before the edge and
   // the registered outputs after it against the model.
   task automatic apply(input logic r, input logic [3:0] alu, input logic [3:0] we,
                        input logic sc, input logic cc, input logic bv, input logic [1:0] bc,
                        input logic sv, input logic rs);
      logic       taken;
      logic [3:0] nxt;
      rst = r;
      {alu_overflow, alu_negative, alu_carry, alu_zero} = alu;
      flag_we = we; setc = sc; clrc = cc;
      br_valid = bv; br_cond = bc; int_save = sv; int_restore = rs;
      #1;
      taken   = exp_taken(bv, bc, m_ccr);
      br_seen = br_taken;
      if (!r) check("br_taken", {3'b0, br_taken}, {3'b0, taken});
      @(posedge clk);
      if (r) begin
         m_ccr = 4'b0000;
         m_stack.delete();
         m_err = 1'b0;
      end else begin
         nxt = m_ccr;
         if (sv && rs) m_err = 1'b1;
         else if (sv) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_ccr);
         end else if (rs) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else nxt = m_stack.pop_back();
         end
         for (int i = 0; i < 4; i++) if (we[i]) nxt[i] = alu[i];
         if (sc) nxt[1] = 1'b1;
         else if (cc) nxt[1] = 1'b0;
         if (taken) begin
            if (bc == 2'd0) nxt[0] = 1'b0;
            if (bc == 2'd1) nxt[2] = 1'b0;
            if (bc == 2'd2) nxt[1] = 1'b0;
         end
         m_ccr = nxt;
      end
      #1;
      check("ccr", ccr, m_ccr);
      check("stack_full",  {3'b0, stack_full},  {3'b0, m_stack.size() == DEPTH});
      check("stack_empty", {3'b0, stack_empty}, {3'b0, m_stack.size() == 0});
      check("stack_err",   {3'b0, stack_err},   {3'b0, m_err});
   endtask

   // Short-hands for common steps.
   task automatic idle();                    apply(0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 0, 0); endtask
   task automatic do_rst();                  apply(1, 4'h0, 4'h0, 0, 0, 0, 2'd0, 0, 0); endtask
   task automatic wr(input logic [3:0] v);   apply(0, v, 4'hF, 0, 0, 0, 2'd0, 0, 0); endtask
   task automatic jmp(input logic [1:0] c);  apply(0, 4'h0, 4'h0, 0, 0, 1, c, 0, 0); endtask

   initial begin
      // Reset state
      do_rst();
      check("rst_ccr", ccr, 4'b0000);
      check("rst_empty", {3'b0, stack_empty}, 4'h1);

      // ADD writes Z=1,C=1; JZ then taken and clears Z
      wr(4'b0011);
      check("add_ccr", ccr, 4'b0011);
      jmp(2'd0);
      check("jz_taken", {3'b0, br_seen}, 4'h1);
      check("jz_clear", ccr, 4'b0010);

      // JZ not taken with Z=0; JMP taken with ccr=0 leaves ccr alone
      jmp(2'd0);
      check("jz_not_taken", {3'b0, br_seen}, 4'h0);
      wr(4'b0000);
      jmp(2'd3);
      check("jmp_taken", {3'b0, br_seen}, 4'h1);
      check("jmp_ccr", ccr, 4'b0000);

      // setc beats clrc and the ALU write; taken JC clear beats setc
      apply(0, 4'b0000, 4'b0010, 1, 1, 0, 2'd0, 0, 0);
      check("setc_wins", ccr, 4'b0010);
      apply(0, 4'b0000, 4'b0010, 1, 1, 1, 2'd2, 0, 0);
      check("jc_clear_wins", ccr, 4'b0000);

      // Nested saves of 1,2,3,4 fill the stack; a fifth save errors
      wr(4'd1);
      apply(0, 4'd2, 4'hF, 0, 0, 0, 2'd0, 1, 0);
      apply(0, 4'd3, 4'hF, 0, 0, 0, 2'd0, 1, 0);
      apply(0, 4'd4, 4'hF, 0, 0, 0, 2'd0, 1, 0);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 1, 0);
      check("full_after_4", {3'b0, stack_full}, 4'h1);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 1, 0);
      check("overflow_err", {3'b0, stack_err}, 4'h1);
      for (int i = 4; i >= 1; i--) begin
         apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 0, 1);
         check("restore_seq", ccr, 4'(i));
      end
      check("empty_after_pops", {3'b0, stack_empty}, 4'h1);

      // Restore on empty stack errors and leaves ccr alone
      do_rst();
      wr(4'b0101);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 0, 1);
      check("underflow_err", {3'b0, stack_err}, 4'h1);
      check("underflow_ccr", ccr, 4'b0101);

      // Simultaneous save and restore: error, depth unchanged, flag write still applies
      do_rst();
      wr(4'b0110);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 1, 0);
      apply(0, 4'b1000, 4'b1000, 0, 0, 0, 2'd0, 1, 1);
      check("both_err", {3'b0, stack_err}, 4'h1);
      check("both_ccr", ccr, 4'b1110);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 0, 1);
      check("both_depth_kept", ccr, 4'b0110);

      // Reset between save and restore discards the saved word
      do_rst();
      wr(4'b1010);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 1, 0);
      do_rst();
      check("mid_rst_ccr", ccr, 4'b0000);
      check("mid_rst_empty", {3'b0, stack_empty}, 4'h1);
      apply(0, 4'd0, 4'h0, 0, 0, 0, 2'd0, 0, 1);
      check("mid_rst_restore_err", {3'b0, stack_err}, 4'h1);

      // Randomized traffic against the model; occasional reset clears sticky error
      do_rst();
      for (int n = 0; n < 1500; n++) begin
         apply(($urandom_range(0, 99) == 0),
               4'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom), 2'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
